// File: rtl/riscv_multicycle_core.sv
// Multicycle 16-bit-encoded RISC core: FETCH/DECODE/EXEC/MEM/WB/HALT over one shared word-addressed memory port.
// Define RISCV_MC_MUL_EN to turn op C into MUL; otherwise op C retires as a NOP.
module riscv_multicycle_core #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 16,
  parameter int RESET_PC = 0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              retire,
  output logic              halted
);

  localparam logic [2:0] STATE_FETCH  = 3'd0;
  localparam logic [2:0] STATE_DECODE = 3'd1;
  localparam logic [2:0] STATE_EXEC   = 3'd2;
  localparam logic [2:0] STATE_MEM    = 3'd3;
  localparam logic [2:0] STATE_WB     = 3'd4;
  localparam logic [2:0] STATE_HALT   = 3'd5;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLT  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LW   = 4'h7;
  localparam logic [3:0] OP_SW   = 4'h8;
  localparam logic [3:0] OP_BEQ  = 4'h9;
  localparam logic [3:0] OP_BNE  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;
`ifdef RISCV_MC_MUL_EN
  localparam logic [3:0] OP_MUL  = 4'hC;
`endif

  localparam logic [ADDR_W-1:0] RESET_PC_W = ADDR_W'(RESET_PC);

  logic [2:0]        state_reg, state_next;
  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [15:0]       ir_reg;
  logic [DATA_W-1:0] a_reg, b_reg, c_reg, res_reg, out_data_reg;
  logic              taken_reg, taken_next;
  logic [DATA_W-1:0] alu_res;
  logic              writes_rd;
  logic [DATA_W-1:0] rf [8];

  logic [3:0]        op;
  logic [DATA_W-1:0] imm_ext;

  assign op      = ir_reg[15:12];
  assign imm_ext = {{(DATA_W-6){ir_reg[5]}}, ir_reg[5:0]};

  // Ops 0..7 all write ra; MUL joins them when the multiplier is built in.
`ifdef RISCV_MC_MUL_EN
  assign writes_rd = (op[3] == 1'b0) || (op == OP_MUL);
`else
  assign writes_rd = (op[3] == 1'b0);
`endif

  genvar gi;
  assign rf[0] = '0;
  for (gi = 1; gi < 8; gi++) begin : g_rf
    logic [DATA_W-1:0] val_reg;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        val_reg <= '0;
      end else if (state_reg == STATE_WB && writes_rd && ir_reg[11:9] == 3'(gi)) begin
        val_reg <= res_reg;
      end
    end
    assign rf[gi] = val_reg;
  end

  always_comb begin
    alu_res = '0;
    case (op)
      OP_ADD:                 alu_res = b_reg + c_reg;
      OP_SUB:                 alu_res = b_reg - c_reg;
      OP_AND:                 alu_res = b_reg & c_reg;
      OP_OR:                  alu_res = b_reg | c_reg;
      OP_XOR:                 alu_res = b_reg ^ c_reg;
      OP_SLT:                 alu_res = {{(DATA_W-1){1'b0}}, ($signed(b_reg) < $signed(c_reg))};
      OP_ADDI, OP_LW, OP_SW:  alu_res = b_reg + imm_ext;
`ifdef RISCV_MC_MUL_EN
      OP_MUL:                 alu_res = b_reg * c_reg;
`endif
      default:                alu_res = '0;
    endcase
  end

  assign taken_next = ((op == OP_BEQ) && (a_reg == b_reg)) || ((op == OP_BNE) && (a_reg != b_reg));
  assign pc_next    = taken_reg ? (pc_reg + ADDR_W'(1) + imm_ext[ADDR_W-1:0]) : (pc_reg + ADDR_W'(1));

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      STATE_FETCH:  if (mem_ready) state_next = STATE_DECODE;
      STATE_DECODE: state_next = STATE_EXEC;
      STATE_EXEC:   state_next = (op == OP_LW || op == OP_SW) ? STATE_MEM : STATE_WB;
      STATE_MEM:    if (mem_ready) state_next = STATE_WB;
      STATE_WB:     state_next = (op == OP_HALT) ? STATE_HALT : STATE_FETCH;
      STATE_HALT:   state_next = STATE_HALT;
      default:      state_next = STATE_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= STATE_FETCH;
      pc_reg       <= RESET_PC_W;
      ir_reg       <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      c_reg        <= '0;
      res_reg      <= '0;
      taken_reg    <= 1'b0;
      out_data_reg <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        STATE_FETCH:  if (mem_ready) ir_reg <= mem_rdata[15:0];
        STATE_DECODE: begin
          a_reg <= rf[ir_reg[11:9]];
          b_reg <= rf[ir_reg[8:6]];
          c_reg <= rf[ir_reg[5:3]];
        end
        STATE_EXEC: begin
          res_reg   <= alu_res;
          taken_reg <= taken_next;
        end
        STATE_MEM:    if (mem_ready && op == OP_LW) res_reg <= mem_rdata;
        STATE_WB: begin
          pc_reg <= pc_next;
          if (writes_rd) out_data_reg <= res_reg;
        end
        default: ;
      endcase
    end
  end

  // Gating with rst keeps the bus idle while reset is held, even though the FSM sits in FETCH.
  assign mem_valid = rst && (state_reg == STATE_FETCH || state_reg == STATE_MEM);
  assign mem_we    = (state_reg == STATE_MEM) && (op == OP_SW);
  assign mem_addr  = (state_reg == STATE_MEM) ? res_reg[ADDR_W-1:0] : pc_reg;
  assign mem_wdata = a_reg;
  assign out_data  = out_data_reg;
  assign retire    = (state_reg == STATE_WB);
  assign halted    = (state_reg == STATE_HALT);

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Scoreboard bench for riscv_multicycle_core with a wait-state memory model (separate fetch/data latency).
module tb_riscv_multicycle_core;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_valid, mem_we, mem_ready, retire, halted;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, out_data;

  logic [15:0] mem [0:65535];
  int          wait_fetch = 0;
  int          wait_data  = 0;
  int          wcnt       = 0;
  logic        fetch_phase;
  int          total = 0;
  int          bad   = 0;
  int          exp_q[$];

  always #5 clk = ~clk;

  riscv_multicycle_core dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (mem_valid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .out_data  (out_data),
    .retire    (retire),
    .halted    (halted)
  );

  assign mem_rdata = mem[mem_addr];
  assign mem_ready = mem_valid && (wcnt == (fetch_phase ? wait_fetch : wait_data));

  always @(posedge clk) begin
    if (!mem_valid || mem_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
    if (mem_valid && mem_ready && mem_we) mem[mem_addr] = mem_wdata;
  end

  // The first request after reset or after a retire is the instruction fetch.
  always @(posedge clk or negedge rst) begin
    if (!rst) fetch_phase <= 1'b1;
    else if (retire) fetch_phase <= 1'b1;
    else if (mem_valid && mem_ready) fetch_phase <= 1'b0;
  end

  function automatic logic [15:0] enc_r(input logic [3:0] op, input int ra, input int rb, input int rc);
    return {op, 3'(ra), 3'(rb), 3'(rc), 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input int ra, input int rb, input int imm);
    return {op, 3'(ra), 3'(rb), 6'(imm)};
  endfunction

  task automatic hold_reset();
    rst = 1'b0;
    wait_fetch = 0;
    wait_data = 0;
    exp_q.delete();
    for (int i = 0; i < 65536; i++) mem[i] = 16'hB000;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic wait_retire(input int budget, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (retire === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit ok;
    int cyc;
    int exp;
    hold_reset();
    mem[0] = enc_i(4'h6, 1, 0, 5);
    exp_q.push_back(5);
    total++;
    if (mem_valid !== 1'b0 || retire !== 1'b0 || halted !== 1'b0 || out_data !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b retire=%b halted=%b out=%h required 0 0 0 0000",
               mem_valid, retire, halted, out_data);
    end
    rst = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL first_fetch: valid=%b we=%b addr=%h required 1 0 0000", mem_valid, mem_we, mem_addr);
    end
    wait_retire(50, ok, cyc);
    total++;
    if (!ok) begin bad++; $display("FAIL reset_retire_timeout: got none required retire"); end
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    total++;
    if (out_data !== 16'(exp)) begin
      bad++;
      $display("FAIL reset_addi: out=%h required %h", out_data, 16'(exp));
    end
    $display("test_reset: out_data=%h", out_data);
  endtask

  task automatic test_alu();
    bit ok;
    int cyc;
    int exp;
    int n;
    hold_reset();
    mem[0]  = enc_i(4'h6, 1, 0, 5);    exp_q.push_back('h0005);
    mem[1]  = enc_i(4'h6, 2, 0, -3);   exp_q.push_back('hFFFD);
    mem[2]  = enc_r(4'h0, 3, 1, 2);    exp_q.push_back('h0002);
    mem[3]  = enc_r(4'h1, 4, 1, 2);    exp_q.push_back('h0008);
    mem[4]  = enc_r(4'h2, 5, 1, 2);    exp_q.push_back('h0005);
    mem[5]  = enc_r(4'h3, 6, 1, 2);    exp_q.push_back('hFFFD);
    mem[6]  = enc_r(4'h4, 7, 1, 2);    exp_q.push_back('hFFF8);
    mem[7]  = enc_r(4'h5, 4, 2, 1);    exp_q.push_back('h0001);
    mem[8]  = enc_r(4'h5, 4, 1, 2);    exp_q.push_back('h0000);
    mem[9]  = enc_r(4'h0, 0, 1, 1);    exp_q.push_back('h000A);
    mem[10] = enc_r(4'h0, 4, 0, 1);    exp_q.push_back('h0005);
    n = exp_q.size();
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_retire(50, ok, cyc);
      total++;
      if (!ok) begin bad++; $display("FAIL alu_timeout[%0d]: got none required retire", i); end
      if (i > 0) begin
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL alu_cycles[%0d]: got %0d required 4", i, cyc); end
      end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (out_data !== 16'(exp)) begin
        bad++;
        $display("FAIL alu_out[%0d]: got %h required %h", i, out_data, 16'(exp));
      end
      $display("test_alu: instr %0d out_data=%h cycles=%0d", i, out_data, cyc);
    end
  endtask

  task automatic test_mem_wait();
    bit   ok;
    int   cyc;
    int   dcyc;
    int   exp;
    logic is_sw;
    logic [15:0] addr_exp [4];
    hold_reset();
    wait_data = 2;
    mem[11] = 16'h1234;
    mem[10] = 16'h7777;
    mem[0] = enc_i(4'h6, 1, 0, 5);    exp_q.push_back('h0005);
    mem[1] = enc_i(4'h6, 2, 0, -3);   exp_q.push_back('hFFFD);
    mem[2] = enc_r(4'h0, 3, 1, 2);    exp_q.push_back('h0002);
    mem[3] = enc_i(4'h8, 3, 0, 10);   exp_q.push_back('h0002);
    mem[4] = enc_i(4'h7, 4, 0, 10);   exp_q.push_back('h0002);
    mem[5] = enc_i(4'h7, 6, 0, 11);   exp_q.push_back('h1234);
    mem[6] = enc_r(4'h0, 5, 4, 4);    exp_q.push_back('h0004);
    addr_exp[0] = 16'd10; addr_exp[1] = 16'd10; addr_exp[2] = 16'd11; addr_exp[3] = 16'd0;
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      is_sw = (i == 3);
      ok = 1'b0; cyc = 0; dcyc = 0;
      while (!ok && cyc < 60) begin
        @(negedge clk);
        cyc++;
        if (mem_valid === 1'b1 && fetch_phase === 1'b0) begin
          dcyc++;
          total++;
          if (mem_addr !== addr_exp[i-3] || mem_we !== is_sw || (is_sw && mem_wdata !== 16'h0002)) begin
            bad++;
            $display("FAIL mem_hold[%0d]: addr=%h we=%b wdata=%h required %h %b 0002",
                     i, mem_addr, mem_we, mem_wdata, addr_exp[i-3], is_sw);
          end
        end
        if (retire === 1'b1) ok = 1'b1;
      end
      total++;
      if (!ok) begin bad++; $display("FAIL mem_timeout[%0d]: got none required retire", i); end
      if (i >= 3 && i <= 5) begin
        total++;
        if (cyc !== 7 || dcyc !== 3) begin
          bad++;
          $display("FAIL mem_cycles[%0d]: got %0d/%0d required 7/3", i, cyc, dcyc);
        end
      end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (out_data !== 16'(exp)) begin
        bad++;
        $display("FAIL mem_out[%0d]: got %h required %h", i, out_data, 16'(exp));
      end
      $display("test_mem_wait: instr %0d out_data=%h cycles=%0d data_cycles=%0d", i, out_data, cyc, dcyc);
    end
    total++;
    if (mem[10] !== 16'h0002) begin bad++; $display("FAIL sw_store: got %h required 0002", mem[10]); end
  endtask

  task automatic test_branch();
    bit ok;
    int cyc;
    int exp;
    int n;
    hold_reset();
    mem[0] = enc_i(4'h6, 1, 0, 5);    exp_q.push_back(1);
    mem[1] = enc_i(4'hA, 1, 1, 3);    exp_q.push_back(2);
    mem[2] = enc_i(4'hA, 1, 0, 1);    exp_q.push_back(4);
    mem[3] = 16'hF000;
    mem[4] = enc_i(4'h9, 1, 1, -1);   exp_q.push_back(4);
    exp_q.push_back(4);
    n = exp_q.size();
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_retire(50, ok, cyc);
      total++;
      if (!ok || cyc > 4) begin bad++; $display("FAIL br_timing[%0d]: got ok=%0d cycles=%0d required retire within 4", i, ok, cyc); end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (mem_valid !== 1'b1 || mem_addr !== 16'(exp)) begin
        bad++;
        $display("FAIL br_fetch[%0d]: got valid=%b addr=%h required 1 %h", i, mem_valid, mem_addr, 16'(exp));
      end
      $display("test_branch: step %0d next fetch=%h", i, mem_addr);
    end
    hold_reset();
    mem[0]        = enc_i(4'h9, 0, 0, -2);  exp_q.push_back('hFFFF);
    mem[16'hFFFF] = enc_i(4'h9, 0, 0, -1);  exp_q.push_back('hFFFF);
    exp_q.push_back('hFFFF);
    n = exp_q.size();
    rst = 1'b1;
    for (int i = 0; i < n; i++) begin
      wait_retire(50, ok, cyc);
      total++;
      if (!ok) begin bad++; $display("FAIL wrap_timeout[%0d]: got none required retire", i); end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (mem_addr !== 16'(exp) || out_data !== 16'h0000) begin
        bad++;
        $display("FAIL wrap_fetch[%0d]: got addr=%h out=%h required %h 0000", i, mem_addr, out_data, 16'(exp));
      end
      $display("test_branch: wrap step %0d next fetch=%h", i, mem_addr);
    end
  endtask

  task automatic test_halt();
    bit ok;
    int cyc;
    int exp;
    hold_reset();
    mem[0] = enc_i(4'h6, 1, 0, 5);  exp_q.push_back(5);
    mem[1] = enc_i(4'h6, 2, 0, 3);  exp_q.push_back(3);
    mem[2] = 16'hF000;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      wait_retire(50, ok, cyc);
      total++;
      if (!ok) begin bad++; $display("FAIL halt_pre_timeout[%0d]: got none required retire", i); end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (out_data !== 16'(exp)) begin bad++; $display("FAIL halt_pre_out[%0d]: got %h required %h", i, out_data, 16'(exp)); end
    end
    wait_retire(50, ok, cyc);
    total++;
    if (!ok || halted !== 1'b0) begin bad++; $display("FAIL halt_retire: got ok=%0d halted=%b required 1 0", ok, halted); end
    @(posedge clk); #1;
    total++;
    if (halted !== 1'b1) begin bad++; $display("FAIL halt_flag: got %b required 1", halted); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      total++;
      if (mem_valid !== 1'b0 || halted !== 1'b1 || retire !== 1'b0) begin
        bad++;
        $display("FAIL halt_idle[%0d]: valid=%b halted=%b retire=%b required 0 1 0", i, mem_valid, halted, retire);
      end
    end
    total++;
    if (out_data !== 16'h0003) begin bad++; $display("FAIL halt_out: got %h required 0003", out_data); end
    $display("test_halt: halted=%b out_data=%h", halted, out_data);
    rst = 1'b0;
    #1;
    total++;
    if (halted !== 1'b0) begin bad++; $display("FAIL halt_reset: got %b required 0", halted); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL halt_restart: valid=%b addr=%h required 1 0000", mem_valid, mem_addr);
    end
    wait_retire(50, ok, cyc);
    @(posedge clk); #1;
    total++;
    if (!ok || out_data !== 16'h0005) begin bad++; $display("FAIL halt_rerun: got ok=%0d out=%h required 1 0005", ok, out_data); end
  endtask

  task automatic test_reset_mid_lw();
    bit ok;
    int cyc;
    int exp;
    hold_reset();
    wait_data = 5;
    mem[10] = 16'h0055;
    mem[0] = enc_i(4'h6, 4, 0, 7);   exp_q.push_back('h0007);
    mem[1] = enc_i(4'h7, 4, 0, 10);
    mem[2] = enc_r(4'h0, 5, 4, 0);
    rst = 1'b1;
    wait_retire(50, ok, cyc);
    @(posedge clk); #1;
    exp = exp_q.pop_front();
    total++;
    if (!ok || out_data !== 16'(exp)) begin bad++; $display("FAIL midlw_first: got ok=%0d out=%h required 1 %h", ok, out_data, 16'(exp)); end
    ok = 1'b0; cyc = 0;
    while (!ok && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_valid === 1'b1 && fetch_phase === 1'b0) ok = 1'b1;
    end
    @(negedge clk);
    @(negedge clk);
    total++;
    if (!ok || mem_valid !== 1'b1 || mem_ready !== 1'b0 || mem_addr !== 16'd10) begin
      bad++;
      $display("FAIL midlw_stall: got ok=%0d valid=%b ready=%b addr=%h required 1 1 0 000a", ok, mem_valid, mem_ready, mem_addr);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if (mem_valid !== 1'b0 || retire !== 1'b0 || out_data !== 16'h0000) begin
      bad++;
      $display("FAIL midlw_abort: valid=%b retire=%b out=%h required 0 0 0000", mem_valid, retire, out_data);
    end
    @(negedge clk);
    wait_data = 0;
    exp_q.push_back('h0007);
    exp_q.push_back('h0055);
    exp_q.push_back('h0055);
    rst = 1'b1;
    #1;
    total++;
    if (mem_valid !== 1'b1 || mem_addr !== 16'h0000) begin
      bad++;
      $display("FAIL midlw_restart: valid=%b addr=%h required 1 0000", mem_valid, mem_addr);
    end
    for (int i = 0; i < 3; i++) begin
      wait_retire(50, ok, cyc);
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (!ok || out_data !== 16'(exp)) begin
        bad++;
        $display("FAIL midlw_rerun[%0d]: got ok=%0d out=%h required 1 %h", i, ok, out_data, 16'(exp));
      end
      $display("test_reset_mid_lw: instr %0d out_data=%h", i, out_data);
    end
  endtask

  task automatic test_mul();
    bit ok;
    int cyc;
    int exp;
    hold_reset();
    mem[0] = enc_i(4'h6, 1, 0, 5);   exp_q.push_back('h0005);
    mem[1] = enc_i(4'h6, 2, 0, -3);  exp_q.push_back('hFFFD);
    mem[2] = enc_i(4'h6, 5, 0, 9);   exp_q.push_back('h0009);
    mem[3] = enc_r(4'hC, 5, 1, 2);
    mem[4] = enc_r(4'h0, 6, 5, 0);
`ifdef RISCV_MC_MUL_EN
    exp_q.push_back('hFFF1);
    exp_q.push_back('hFFF1);
`else
    exp_q.push_back('h0009);
    exp_q.push_back('h0009);
`endif
    rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_retire(50, ok, cyc);
      total++;
      if (!ok) begin bad++; $display("FAIL mul_timeout[%0d]: got none required retire", i); end
      if (i == 3) begin
        total++;
        if (cyc !== 4) begin bad++; $display("FAIL mul_cycles: got %0d required 4", cyc); end
      end
      @(posedge clk); #1;
      exp = exp_q.pop_front();
      total++;
      if (out_data !== 16'(exp)) begin
        bad++;
        $display("FAIL mul_out[%0d]: got %h required %h", i, out_data, 16'(exp));
      end
      $display("test_mul: instr %0d out_data=%h cycles=%0d", i, out_data, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_mem_wait();
    test_branch();
    test_halt();
    test_reset_mid_lw();
    test_mul();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
